// File: rtl/ceespu_ifetch.sv
// ceespu_ifetch: instruction fetch queue between the program counter and decode.
// Optional macro CEESPU_IFETCH_BYPASS_EN forwards the in-flight word to decode when the queue is empty.
module ceespu_ifetch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [13:0] I_PC,
  input  logic        I_branch,
  output logic        O_stall,
  output logic        O_imem_en,
  output logic [13:0] O_imem_addr,
  input  logic [31:0] I_imem_data,
  output logic        O_valid,
  output logic [31:0] O_instr,
  output logic [13:0] O_instr_PC,
  input  logic        I_dec_ready
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned PC_W    = 14;
  localparam int unsigned INSTR_W = 32;

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_inflight;
  logic [PC_W-1:0]    r_inflight_pc;

  logic w_flush;
  logic w_empty;
  logic w_stall;
  logic w_issue;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_flush = I_rst | I_branch;
  assign w_empty = (r_count == '0);
  // Pops in the current cycle are deliberately not credited against the stall.
  assign w_stall = (r_count + CNT_W'(r_inflight)) >= CNT_W'(DEPTH);
  assign w_issue = ~w_stall & ~I_branch & ~I_rst;

`ifdef CEESPU_IFETCH_BYPASS_EN
  assign w_bypass = w_empty & r_inflight & ~w_flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word taken by decode is never written into the queue.
  assign w_push = r_inflight & ~w_flush & ~(w_bypass & I_dec_ready);
  assign w_pop  = ~w_empty & I_dec_ready & ~w_flush;

  assign O_stall     = w_stall;
  assign O_imem_en   = w_issue;
  assign O_imem_addr = I_PC;

  // Head presentation: bypassed response, queue head, or zeros when empty.
  always_comb begin
    O_valid    = 1'b0;
    O_instr    = '0;
    O_instr_PC = '0;
    if (w_bypass) begin
      O_valid    = 1'b1;
      O_instr    = I_imem_data;
      O_instr_PC = r_inflight_pc;
    end else if (!w_empty) begin
      O_valid    = 1'b1;
      O_instr    = r_instr[r_rd_ptr];
      O_instr_PC = r_pc[r_rd_ptr];
    end
  end

  // Control state: pointers, occupancy and in-flight tracking.
  always_ff @(posedge I_clk) begin
    if (w_flush) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= I_PC;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset; entries are only read when counted valid.
  always_ff @(posedge I_clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= I_imem_data;
      r_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  a_no_overflow: assert property (@(posedge I_clk) disable iff (I_rst)
    !(w_push && (r_count == CNT_W'(DEPTH))));

endmodule
